// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write-side FIFO, runtime baud divisor, oversampled bit timing,
// selectable parity and line-break generation.
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic [1:0]                    data_bit_num,
    input  logic                          stop_bit_num,
    input  logic                          parity_en,
    input  logic [1:0]                    parity_type,
    input  logic                          break_req,
    input  logic                          cts_n,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx,
    output logic                          busy,
    output logic                          tx_done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop1, StStop2, StBreak
    } state_e;

    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 push, pop;

    state_e               state_q;
    logic [DIV_WIDTH-1:0] div_lat_q, div_cnt_q;
    logic [TW-1:0]        tick_q;
    logic [7:0]           data_q;
    logic [2:0]           last_idx_q, bit_idx_q, next_idx;
    logic                 par_en_q, stop2_q, frame_q, tx_q, done_q;
    logic [1:0]           par_type_q;
    logic                 div_tick, bit_end, par_xor, parity_bit;
    logic [7:0]           data_masked;

    assign wr_ready   = (count_q < CW'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready;
    // Break outranks a pending pop, and cts_n only matters while idle.
    assign pop        = (state_q == StIdle) && !break_req && !cts_n && (count_q != '0);
    assign fifo_count = count_q;
    assign tx         = tx_q;
    assign tx_done    = done_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign div_tick    = (div_cnt_q == div_lat_q);
    assign bit_end     = div_tick && (tick_q == TW'(OVERSAMPLE - 1));
    assign next_idx    = bit_idx_q + 3'd1;
    assign data_masked = data_q & (8'hFF >> (3'd7 - last_idx_q));
    assign par_xor     = ^data_masked;

    always_comb begin
        parity_bit = 1'b0;
        unique case (par_type_q)
            2'b00: parity_bit = ~par_xor;
            2'b01: parity_bit = par_xor;
            2'b10: parity_bit = 1'b1;
            2'b11: parity_bit = 1'b0;
            default: parity_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            div_lat_q  <= '0;
            div_cnt_q  <= '0;
            tick_q     <= '0;
            data_q     <= '0;
            last_idx_q <= '0;
            bit_idx_q  <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= '0;
            stop2_q    <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (div_tick) begin
                div_cnt_q <= '0;
                tick_q    <= (tick_q == TW'(OVERSAMPLE - 1)) ? '0 : tick_q + 1'b1;
            end else begin
                div_cnt_q <= div_cnt_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    tx_q      <= 1'b1;
                    div_cnt_q <= '0;
                    tick_q    <= '0;
                    if (break_req) begin
                        state_q   <= StBreak;
                        tx_q      <= 1'b0;
                        frame_q   <= 1'b0;
                        div_lat_q <= baud_div;
                    end else if (pop) begin
                        state_q    <= StStart;
                        tx_q       <= 1'b0;
                        frame_q    <= 1'b1;
                        data_q     <= mem_q[rptr_q];
                        div_lat_q  <= baud_div;
                        last_idx_q <= {1'b1, data_bit_num};
                        par_en_q   <= parity_en;
                        par_type_q <= parity_type;
                        stop2_q    <= stop_bit_num;
                        bit_idx_q  <= '0;
                    end
                end
                StBreak: begin
                    div_cnt_q <= '0;
                    tick_q    <= '0;
                    if (!break_req) begin
                        state_q <= StStop1;
                        tx_q    <= 1'b1;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        state_q <= StData;
                        tx_q    <= data_q[0];
                    end
                end
                StData: begin
                    if (bit_end) begin
                        if (bit_idx_q == last_idx_q) begin
                            state_q <= par_en_q ? StParity : StStop1;
                            tx_q    <= par_en_q ? parity_bit : 1'b1;
                        end else begin
                            bit_idx_q <= next_idx;
                            tx_q      <= data_q[next_idx];
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_q <= StStop1;
                        tx_q    <= 1'b1;
                    end
                end
                StStop1: begin
                    if (bit_end) begin
                        // A break's trailing mark is a single stop bit with no completion pulse.
                        if (frame_q && stop2_q) begin
                            state_q <= StStop2;
                        end else begin
                            state_q <= StIdle;
                            done_q  <= frame_q;
                        end
                    end
                end
                StStop2: begin
                    if (bit_end) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench: stimulus queues expected frames/breaks, a monitor decodes the tx line.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned OS    = 16;
    localparam int unsigned DW    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] baud_div = '0;
    logic [1:0]    data_bit_num = 2'b11;
    logic          stop_bit_num = 1'b0;
    logic          parity_en = 1'b0;
    logic [1:0]    parity_type = 2'b00;
    logic          break_req = 1'b0;
    logic          cts_n = 1'b1;
    logic [7:0]    wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic          tx, busy, tx_done;

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OS), .DIV_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .baud_div(baud_div), .data_bit_num(data_bit_num),
        .stop_bit_num(stop_bit_num), .parity_en(parity_en), .parity_type(parity_type),
        .break_req(break_req), .cts_n(cts_n), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .fifo_count(fifo_count), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_break;
        logic [7:0] data;
        int         nbits;
        bit         par_en;
        logic [1:0] ptype;
        bit         stop2;
        int         blen;
        int         brk_cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_t e;
        e.is_break   = 1'b0;
        e.data       = d;
        e.nbits      = 5 + int'(data_bit_num);
        e.par_en     = parity_en;
        e.ptype      = parity_type;
        e.stop2      = stop_bit_num;
        e.blen       = (int'(baud_div) + 1) * OS;
        e.brk_cycles = 0;
        sb.push_back(e);
    endtask

    task automatic push_break(input int h);
        exp_t e;
        e.is_break   = 1'b1;
        e.data       = '0;
        e.nbits      = 0;
        e.par_en     = 1'b0;
        e.ptype      = '0;
        e.stop2      = 1'b0;
        e.blen       = (int'(baud_div) + 1) * OS;
        e.brk_cycles = h;
        sb.push_back(e);
    endtask

    // Offers one word and holds it until the FIFO takes it.
    task automatic write_word(input logic [7:0] d, input bit expect_frame);
        int t = 0;
        wr_data  = d;
        wr_valid = 1'b1;
        while (wr_ready !== 1'b1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("write accepted in time", 32'(t < 20000), 1);
        @(negedge clk);
        wr_valid = 1'b0;
        if (expect_frame) push_frame(d);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy !== 1'b0 || sb.size() != 0 || mon_busy) && t < 40000) begin
            @(negedge clk);
            t++;
        end
        check("drain before timeout", 32'(t < 40000), 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (tx_done !== 1'b1 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("tx_done seen in time", 32'(t < 20000), 1);
    endtask

    // Monitor: expected bit streams come from the frame rules, not from the RTL structure.
    initial begin
        exp_t e;
        bit   bits[$];
        int   t, ones, low;
        bit   ok, par;
        forever begin
            while (sb.size() == 0) @(negedge clk);
            mon_busy = 1'b1;
            e = sb[0];
            t = 0;
            while (tx !== 1'b0 && t < 20000) begin
                @(negedge clk);
                t++;
            end
            check("line activity before timeout", 32'(t < 20000), 1);
            if (t < 20000 && !e.is_break) begin
                bits.delete();
                bits.push_back(1'b0);
                ones = 0;
                for (int i = 0; i < e.nbits; i++) begin
                    bits.push_back(e.data[i]);
                    ones += int'(e.data[i]);
                end
                if (e.par_en) begin
                    case (e.ptype)
                        2'b00: par = (ones % 2 == 0);
                        2'b01: par = (ones % 2 == 1);
                        2'b10: par = 1'b1;
                        default: par = 1'b0;
                    endcase
                    bits.push_back(par);
                end
                bits.push_back(1'b1);
                if (e.stop2) bits.push_back(1'b1);
                for (int k = 0; k < bits.size(); k++) begin
                    ok = 1'b1;
                    for (int c = 0; c < e.blen; c++) begin
                        if (tx !== bits[k] || tx_done !== 1'b0) ok = 1'b0;
                        @(negedge clk);
                    end
                    check($sformatf("frame %02h bit %0d", e.data, k), 32'(ok), 1);
                end
                check($sformatf("frame %02h tx_done at end", e.data), 32'(tx_done), 1);
                check($sformatf("frame %02h idle tx", e.data), 32'(tx), 1);
            end else if (t < 20000) begin
                low = 0;
                while (tx === 1'b0 && low < 20000) begin
                    low++;
                    @(negedge clk);
                end
                check("break low length", 32'(low), 32'(e.brk_cycles));
                ok = 1'b1;
                for (int c = 0; c < e.blen; c++) begin
                    if (tx !== 1'b1 || tx_done !== 1'b0) ok = 1'b0;
                    @(negedge clk);
                end
                check("break trailing mark", 32'(ok), 1);
                check("no tx_done after break", 32'(tx_done), 0);
                check("idle after break", 32'(busy), 0);
            end
            void'(sb.pop_front());
            mon_busy = 1'b0;
        end
    end

    initial begin
        logic [7:0] words [5];
        int         model_cnt;
        int         nw;
        bit         ok;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset tx", 32'(tx), 1);
        check("reset wr_ready", 32'(wr_ready), 1);
        check("reset fifo_count", 32'(fifo_count), 0);
        check("reset busy", 32'(busy), 0);
        check("reset tx_done", 32'(tx_done), 0);

        // 8N1 at the fastest rate.
        cts_n = 1'b0;
        write_word(8'hA5, 1'b1);
        wait_idle();

        // 7E2 then 5 bits with mark parity.
        baud_div = 16'd2; data_bit_num = 2'b10; parity_en = 1'b1;
        parity_type = 2'b01; stop_bit_num = 1'b1;
        write_word(8'hFF, 1'b1);
        wait_idle();
        data_bit_num = 2'b00; parity_type = 2'b10;
        write_word(8'h00, 1'b1);
        wait_idle();

        // Fill to capacity with cts held off.
        baud_div = '0; data_bit_num = 2'b11; parity_en = 1'b0; stop_bit_num = 1'b0;
        cts_n = 1'b1;
        model_cnt = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = words[i];
            check($sformatf("fill wr_ready %0d", i), 32'(wr_ready), 32'(model_cnt < DEPTH));
            if (model_cnt < DEPTH) begin
                push_frame(words[i]);
                model_cnt++;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        check("full fifo_count", 32'(fifo_count), 32'(model_cnt));
        check("full wr_ready", 32'(wr_ready), 0);
        cts_n = 1'b0;
        wait_idle();
        check("drained fifo_count", 32'(fifo_count), 0);

        // cts_n deasserted mid-frame: current frame completes, next one is held.
        write_word(8'h3C, 1'b1);
        write_word(8'hC3, 1'b1);
        repeat (40) @(negedge clk);
        cts_n = 1'b1;
        wait_done();
        repeat (300) @(negedge clk);
        check("held fifo_count", 32'(fifo_count), 1);
        check("held tx", 32'(tx), 1);
        check("held busy", 32'(busy), 1);
        cts_n = 1'b0;
        wait_idle();

        // Break requested mid-frame, then a standalone break at a slower rate.
        write_word(8'h5A, 1'b1);
        repeat (50) @(negedge clk);
        break_req = 1'b1;
        push_break(37);
        wait_done();
        repeat (37) @(negedge clk);
        break_req = 1'b0;
        wait_idle();
        baud_div = 16'd1;
        break_req = 1'b1;
        push_break(20);
        repeat (20) @(negedge clk);
        break_req = 1'b0;
        wait_idle();

        // Randomized frame formats and payloads.
        for (int b = 0; b < 6; b++) begin
            baud_div     = DW'($urandom_range(0, 2));
            data_bit_num = 2'($urandom_range(0, 3));
            stop_bit_num = 1'($urandom_range(0, 1));
            parity_en    = 1'($urandom_range(0, 1));
            parity_type  = 2'($urandom_range(0, 3));
            nw = int'($urandom_range(1, 5));
            for (int i = 0; i < nw; i++) write_word(8'($urandom), 1'b1);
            wait_idle();
        end

        // Reset in the middle of a frame with words still queued.
        baud_div = '0; data_bit_num = 2'b11; parity_en = 1'b0; stop_bit_num = 1'b0;
        cts_n = 1'b1;
        for (int i = 0; i < 4; i++) write_word(words[i], 1'b0);
        cts_n = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid-frame reset tx", 32'(tx), 1);
        check("mid-frame reset fifo_count", 32'(fifo_count), 0);
        check("mid-frame reset busy", 32'(busy), 0);
        check("mid-frame reset wr_ready", 32'(wr_ready), 1);
        check("mid-frame reset tx_done", 32'(tx_done), 0);
        ok = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        check("no stale frame after reset", 32'(ok), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
